// File: rtl/active_rx_pkg.sv
// -----------------------------------------------------------------------------
// active_rx_pkg
//
// Purpose:
//   Shared types and constants for the active_rx byte-to-word receiver.
//   Imported by active_rx (top) and active_rx_fifo (word storage).
//
// Contents:
//   word_t        16-bit packed word, {high byte, low byte}
//   pack_state_e  packer state: LOW waits for the low byte, HIGH for the high
//   DROP_MAX      saturation value of the dropped-word counter
//
// Configuration:
//   ACTIVE_RX_STATS_EN (used in active_rx) enables the overflow flag and the
//   dropped-word counter. Nothing in this package depends on it.
// -----------------------------------------------------------------------------
package active_rx_pkg;

    // A completed word always holds the first byte of the pair in [7:0].
    typedef logic [15:0] word_t;

    // Only two states are needed because a word is exactly two bytes long.
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_e;

    // The drop counter sticks at this value instead of wrapping back to zero.
    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/active_rx_fifo.sv
// -----------------------------------------------------------------------------
// active_rx_fifo
//
// Purpose:
//   Fall-through word FIFO for active_rx. The head entry is presented on
//   rdata_o directly from storage, so a word written on one edge is visible
//   right after that edge. Pointers are log2(DEPTH) bits wide and wrap
//   naturally because DEPTH is a power of two; the separate level counter
//   tells full from empty.
//
// Parameters:
//   DEPTH      number of word entries (power of two, >= 2)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset, clears storage, pointers, level
//   flush_i    synchronous clear of pointers and level, beats push and pop
//   push_i     write wdata_i this edge (caller guarantees a free slot)
//   pop_i      retire the head entry this edge (caller guarantees non-empty)
//   wdata_i    word to write
//   rdata_o    head entry
//   level_o    number of stored words, 0..DEPTH
//   full_o     level_o == DEPTH
//   empty_o    level_o == 0
//
// Configuration:
//   None; ACTIVE_RX_STATS_EN does not affect this module.
// -----------------------------------------------------------------------------
module active_rx_fifo
    import active_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  word_t                  wdata_i,
    output word_t                  rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);

    word_t         mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] wrPtr_d;
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] rdPtr_d;
    logic [PW:0]   level_q;
    logic [PW:0]   level_d;

    // Next-state for the pointers and the level counter. Flush wins over
    // everything else; a simultaneous push and pop moves both pointers but
    // leaves the level where it was.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (push_i) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop_i) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + (PW + 1)'(1);
                2'b01:   level_d = level_q - (PW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Word storage. It is cleared on reset so the head output is a known
    // zero after reset even though nothing valid is stored yet. A write
    // during flush is suppressed since the pointers are being cleared anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Fall-through read: the head entry drives the output directly.
    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/active_rx.sv
// -----------------------------------------------------------------------------
// active_rx
//
// Purpose:
//   Receiver for the upstream byte stream of the active data path. Pairs of
//   accepted bytes are packed into 16-bit words (first byte in the low half)
//   and written into a small fall-through FIFO drained by a ready/valid
//   consumer. The producer cannot be stalled, so a word that completes while
//   the FIFO has no free slot is dropped.
//
// Parameters:
//   DEPTH        FIFO depth in words (power of two, >= 2)
//
// Ports:
//   clk          clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   data_in      upstream byte
//   valid_in     data_in is accepted on this rising edge
//   flush        synchronous clear of packer and FIFO (not of statistics)
//   out_ready    downstream consumer takes the head word
//   word_out     head word {high, low}
//   word_valid   FIFO not empty
//   level        number of words in the FIFO
//   overflow     sticky: at least one word has been dropped
//   drop_count   number of dropped words, saturating at 8'hFF
//
// Configuration:
//   ACTIVE_RX_STATS_EN  when defined, overflow and drop_count track drops;
//                       when undefined they are tied to zero, the counter
//                       logic is absent, and drops still happen silently.
//                       The port list is the same in both builds.
// -----------------------------------------------------------------------------
module active_rx
    import active_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             data_in,
    input  logic                   valid_in,
    input  logic                   flush,
    input  logic                   out_ready,
    output word_t                  word_out,
    output logic                   word_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    pack_state_e packState_q;
    logic [7:0]  lowByte_q;

    logic        pushReq;
    logic        popEn;
    logic        slotFree;
    logic        writeEn;
    logic        dropEvent;
    logic        fifoFull;
    logic        fifoEmpty;
    word_t       packedWord;

    // Byte packer. LOW stores the incoming byte and waits for its partner;
    // HIGH completes the word (see pushReq) and returns to LOW. Flush drops
    // any half-built word by forcing the state back to LOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packState_q <= LOW;
            lowByte_q   <= '0;
        end else if (flush) begin
            packState_q <= LOW;
            lowByte_q   <= '0;
        end else if (valid_in) begin
            case (packState_q)
                LOW: begin
                    lowByte_q   <= data_in;
                    packState_q <= HIGH;
                end
                HIGH: begin
                    packState_q <= LOW;
                end
                default: begin
                    packState_q <= LOW;
                end
            endcase
        end
    end

    // The word is written on the same edge that samples its high byte, so
    // the push request is decoded from the current inputs. A flush in the
    // same cycle discards the word rather than counting it as a drop.
    assign packedWord = {data_in, lowByte_q};
    assign pushReq    = valid_in && (packState_q == HIGH) && !flush;

    // A full FIFO still has a slot this edge if its head is leaving now.
    assign popEn     = word_valid && out_ready;
    assign slotFree  = !fifoFull || popEn;
    assign writeEn   = pushReq && slotFree;
    assign dropEvent = pushReq && !slotFree;

    active_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (writeEn),
        .pop_i   (popEn),
        .wdata_i (packedWord),
        .rdata_o (word_out),
        .level_o (level),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign word_valid = !fifoEmpty;

`ifdef ACTIVE_RX_STATS_EN
    logic       overflow_q;
    logic [7:0] dropCount_q;

    // Drop statistics. Only reset clears them so that software can still
    // see that data was lost after the stream has been flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
        end else if (dropEvent) begin
            overflow_q <= 1'b1;
            if (dropCount_q != DROP_MAX) begin
                dropCount_q <= dropCount_q + 8'd1;
            end
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = dropCount_q;
`else
    logic unusedDropEvent;

    // Statistics are compiled out; the drop decode is kept only so the
    // write path above stays identical between the two builds.
    assign unusedDropEvent = dropEvent;
    assign overflow        = 1'b0;
    assign drop_count      = '0;
`endif

endmodule

// File: tb/tb_active_rx.sv
// -----------------------------------------------------------------------------
// tb_active_rx
//
// Self-checking bench for active_rx (DEPTH = 4). A driver issues one cycle of
// stimulus per call and updates a word-level reference model: every word the
// model accepts is pushed onto an expected-word queue. A separate monitor
// pops that queue whenever the DUT hands a word to the consumer. Directed
// scenarios are followed by a randomized phase and a saturation run.
// Honors ACTIVE_RX_STATS_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_active_rx;
    import active_rx_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data_in = '0;
    logic          valid_in = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    word_t         word_out;
    logic          word_valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_count;

    int    assertCount = 0;
    int    failCount = 0;

    // Reference model state: words in flight, FIFO occupancy, pending low
    // byte and drop statistics, all kept as plain integers and queues.
    word_t expQ[$];
    int    modelLevel = 0;
    bit    modelHasLow = 0;
    logic [7:0] modelLow = '0;
    int    modelDrops = 0;
    bit    modelOverflow = 0;
    word_t monExp;

    active_rx #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .flush      (flush),
        .out_ready  (out_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Single comparison point; four-state compare so X never slips through.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic expOverflow();
`ifdef ACTIVE_RX_STATS_EN
        return modelOverflow;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] expDrops();
`ifdef ACTIVE_RX_STATS_EN
        return 8'(modelDrops);
`else
        return 8'h00;
`endif
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, "_word_valid"}, 32'(word_valid), 32'(modelLevel > 0));
        checkOutput({tag, "_level"}, 32'(level), 32'(modelLevel));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOverflow()));
        checkOutput({tag, "_drop_count"}, 32'(drop_count), 32'(expDrops()));
    endtask

    // One clock of stimulus: check the settled outputs, drive new inputs at
    // the falling edge, then advance the model to what the next rising edge
    // must produce.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic rdy, input logic fl);
        bit    popNow;
        bit    pushNow;
        word_t w;
        @(negedge clk);
        checkState("cyc");
        valid_in  = v;
        data_in   = d;
        flush     = fl;
        out_ready = fl ? 1'b0 : rdy;
        pushNow   = 0;
        w         = '0;
        if (fl) begin
            expQ.delete();
            modelLevel  = 0;
            modelHasLow = 0;
        end else begin
            popNow = (modelLevel > 0) && rdy;
            if (v) begin
                if (modelHasLow) begin
                    pushNow     = 1;
                    w           = {d, modelLow};
                    modelHasLow = 0;
                end else begin
                    modelLow    = d;
                    modelHasLow = 1;
                end
            end
            if (pushNow) begin
                if (modelLevel < DEPTH || popNow) begin
                    expQ.push_back(w);
                    modelLevel++;
                end else begin
                    modelOverflow = 1;
                    if (modelDrops < 255) modelDrops++;
                end
            end
            if (popNow) modelLevel--;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 1'b0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic midReset();
        @(negedge clk);
        valid_in  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_word_valid", 32'(word_valid), 32'd0);
        checkOutput("async_rst_level", 32'(level), 32'd0);
        checkOutput("async_rst_word_out", 32'(word_out), 32'd0);
        checkOutput("async_rst_overflow", 32'(overflow), 32'd0);
        checkOutput("async_rst_drop_count", 32'(drop_count), 32'd0);
        expQ.delete();
        modelLevel    = 0;
        modelHasLow   = 0;
        modelDrops    = 0;
        modelOverflow = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: a pop happens on the next rising edge whenever the DUT shows
    // a valid word while the consumer is ready; that word must be the oldest
    // one the model accepted.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && word_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no word (t=%0t)",
                             word_out, $time);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("word_out", 32'(word_out), 32'(monExp));
                end
            end
        end
    end

    initial begin
        // Reset values.
        #1;
        checkOutput("reset_word_valid", 32'(word_valid), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_word_out", 32'(word_out), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two bytes pack into 16'h1234, visible right after the high byte.
        applyStimulus(1'b1, 8'h34, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t1_word_out", 32'(word_out), 32'h1234);
        checkOutput("t1_word_valid", 32'(word_valid), 32'd1);
        idle(3, 1'b1);

        // Ten bytes with no consumer: four words kept, the fifth dropped.
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t2_level", 32'(level), 32'd4);
        checkOutput("t2_head", 32'(word_out), 32'h0201);
`ifdef ACTIVE_RX_STATS_EN
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        checkOutput("t2_drop_count", 32'(drop_count), 32'd1);
`else
        checkOutput("t2_overflow", 32'(overflow), 32'd0);
        checkOutput("t2_drop_count", 32'(drop_count), 32'd0);
`endif
        idle(6, 1'b1);

        // Full FIFO: a word completing on a pop edge takes the freed slot.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t3_level", 32'(level), 32'd4);
        idle(6, 1'b1);

        // Flush discards the held low byte; only 16'h2211 emerges.
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t4_word_out", 32'(word_out), 32'h2211);
        idle(3, 1'b1);

        // Reset mid-word with three words stored, then pack from LOW again.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        midReset();
        applyStimulus(1'b1, 8'h56, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t5_word_out", 32'(word_out), 32'h7856);
        idle(3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'(($urandom % 4) != 0), 8'($urandom),
                          1'($urandom % 2), 1'(($urandom % 50) == 0));
        end
        idle(6, 1'b1);

        // Force more than 255 drops to reach saturation.
        for (int i = 0; i < 608; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
        @(posedge clk);
        #1;
`ifdef ACTIVE_RX_STATS_EN
        checkOutput("t6_drop_sat", 32'(drop_count), 32'hFF);
        checkOutput("t6_overflow", 32'(overflow), 32'd1);
`else
        checkOutput("t6_drop_sat", 32'(drop_count), 32'd0);
        checkOutput("t6_overflow", 32'(overflow), 32'd0);
`endif
        idle(8, 1'b1);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/active_rx.md
# active_rx

Byte-stream receiver for the `active` data path. It samples the registered `data_out`/`valid` stream produced upstream and packs consecutive byte pairs into 16-bit words, low byte first. Completed words go into a small FIFO that is drained by a downstream ready/valid consumer. The upstream producer has no backpressure, so words that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in words. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  8: byte from the upstream producer.
- `valid_in`  in  1: `data_in` is sampled on each rising edge where this is high.
- `flush`  in  1: synchronous clear of the packer and FIFO.
- `out_ready`  in  1: the downstream consumer accepts the word.
- `word_out`  out  16: FIFO head word, `{high, low}`.
- `word_valid`  out  1: FIFO is not empty.
- `level`  out  $clog2(DEPTH)+1: number of words in the FIFO.
- `overflow`  out  1: sticky flag; at least one word was dropped.
- `drop_count`  out  8: number of dropped words, saturating.

## Operation
- Reset values: `word_out`=16'h0000, `word_valid`=0, `level`=0, `overflow`=0, `drop_count`=0. Packer state is LOW.
- Packer states:
  - LOW: a byte accepted here is stored in the low register, then the state moves to HIGH.
  - HIGH: a byte accepted here completes the word `{data_in, low_reg}` and issues a push request. The state moves back to LOW.
  - When `valid_in`=0 the packer holds its state.
- Push: the word is written when `level`<DEPTH, or when `level`==DEPTH and a pop happens in the same cycle.
- Dropped push: if no write slot is available, the word is discarded. `overflow` is set to 1, and `drop_count` increments unless it is already 8'hFF.
- Pop: happens on an edge where `word_valid`&&`out_ready`. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- `level` behaviour:
  - +1 on a push only.
  - −1 on a pop only.
  - unchanged on a simultaneous push and pop, or when neither occurs.
- `word_out` is driven from the head storage entry. Its value when `word_valid`=0 is don't-care, but it must not be X after reset.
- `flush`=1 clears the packer to LOW (discarding a held low byte), the pointers and `level`.
  - Flush takes priority over a push or pop in the same cycle.
  - Flush does not clear `overflow` or `drop_count`; only `rst_n` clears them.
- An `rst_n` assertion mid-word discards the half-packed byte and all FIFO contents, immediately and asynchronously.

## Timing
- The high byte is sampled at edge N. `word_valid` rises after edge N, with 1-cycle write latency.
- Fall-through: the word is visible the same cycle `word_valid` rises.
- A pop at edge M presents the next entry after edge M. Sustained throughput is 1 word per cycle downstream and 1 byte per cycle upstream.
- `word_valid`, `level`, `overflow` and `drop_count` are registered or decoded from registers only. No combinational path runs from `data_in`/`valid_in` to any output.
- `out_ready` may combinationally affect only the internal pop enable, not any output.

## Configuration
- `ACTIVE_RX_STATS_EN`:
  - Defined: `overflow` and `drop_count` behave as described above.
  - Undefined: both are tied to 0, the counter logic is removed, and drops still occur silently.
- Port list is identical in both builds.

## Structure
- `active_rx_pkg`:
  - `word_t` (logic [15:0]).
  - `pack_state_e` {LOW, HIGH}.
  - `DROP_MAX` = 8'hFF.
- One sub-module, `active_rx_fifo`: parameterised storage, pointers and level, with push/pop/flush inputs.
- `active_rx` holds the packer, the drop and statistics logic, and the FIFO instance.

## Test plan
- Reset then bytes 8'h34, 8'h12 on consecutive cycles with `out_ready`=1 → `word_out`=16'h1234 with `word_valid`=1 for one cycle, then `level` returns to 0.
- `out_ready`=0 with 10 bytes 8'h01..8'h0A, DEPTH=4 → `level`=4, words 16'h0201, 0403, 0605, 0807 kept, 16'h0A09 dropped, `overflow`=1, `drop_count`=1.
- FIFO full, new word completes on the same edge as a pop → no drop and `level` stays 4. Order is preserved on drain.
- 8'hAA accepted, `flush` pulsed, then 8'h11, 8'h22 → only 16'h2211 emerges. `drop_count` is unchanged by the flush.
- `rst_n` asserted low mid-word and while `level`=3 → all outputs go to their reset values immediately, and the next pair packs from LOW.
- 300 forced drops → `drop_count` saturates at 8'hFF. With `ACTIVE_RX_STATS_EN` undefined it stays 0 and `overflow` stays 0.
